// File: rtl/periph_div_initiator.sv
// Bus initiator that drives a memory-mapped divider peripheral through one division.
//
// Sequence per accepted start: write dividend (addr 0), write divisor (addr 1),
// write init=1 then init=0 (addr 2), wait SETTLE_CYC idle cycles, poll ready (addr 3)
// until set or TIMEOUT_POLLS polls fail, read result (addr 4), pulse done.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start                request a division (sampled only in idle)
//   dividend, divisor    operands, captured on start accept
//   busy, done, err      status; err/quotient valid with done, held until next start
//   quotient             result word
//   cs, addr, rd, wr     registered single-cycle peripheral access strobes
//   bus_wdata            write data, zero outside write cycles
//   bus_rdata            registered peripheral read data (valid the cycle after rd)
module periph_div_initiator #(
    parameter int unsigned TIMEOUT_POLLS = 1024,
    parameter int unsigned SETTLE_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] quotient,
    output logic        cs,
    output logic [2:0]  addr,
    output logic        rd,
    output logic        wr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned PollW    = $clog2(TIMEOUT_POLLS + 1);
    localparam int unsigned SettleW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [PollW-1:0]   PollMax    = PollW'(TIMEOUT_POLLS);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYC - 1);

    localparam logic [2:0] AddrA     = 3'd0;
    localparam logic [2:0] AddrB     = 3'd1;
    localparam logic [2:0] AddrInit  = 3'd2;
    localparam logic [2:0] AddrReady = 3'd3;
    localparam logic [2:0] AddrRes   = 3'd4;

    typedef enum logic [3:0] {
        StIdle, StWrA, StWrB, StWrInit, StWrClr, StSettle,
        StRdRdy, StSmpRdy, StRdRes, StSmpRes, StFin
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        divisor_q, divisor_d;
    logic [PollW-1:0]   poll_q, poll_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        quot_q, quot_d;
    logic               cs_q, cs_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [2:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    // Bus registers are loaded with the access belonging to the state being entered,
    // so each strobe is visible for exactly the cycle spent in that state.
    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        poll_d    = poll_q;
        settle_d  = settle_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        quot_d    = quot_q;
        cs_d      = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        addr_d    = 3'd0;
        wdata_d   = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StWrA;
                    divisor_d = divisor;
                    poll_d    = '0;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    quot_d    = 32'd0;
                    cs_d      = 1'b1;
                    wr_d      = 1'b1;
                    addr_d    = AddrA;
                    wdata_d   = dividend;
                end
            end
            StWrA: begin
                state_d = StWrB;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = AddrB;
                wdata_d = divisor_q;
            end
            StWrB: begin
                state_d = StWrInit;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = AddrInit;
                wdata_d = 32'd1;
            end
            StWrInit: begin
                // Second write drops init, leaving a one-cycle-wide init level.
                state_d = StWrClr;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = AddrInit;
                wdata_d = 32'd0;
            end
            StWrClr: begin
                settle_d = '0;
                if (SETTLE_CYC == 0) begin
                    state_d = StRdRdy;
                    cs_d    = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = AddrReady;
                end else begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d = StRdRdy;
                    cs_d    = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = AddrReady;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StRdRdy: begin
                state_d = StSmpRdy;
            end
            StSmpRdy: begin
                if (bus_rdata[0]) begin
                    state_d = StRdRes;
                    cs_d    = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = AddrRes;
                end else begin
                    poll_d = poll_q + 1'b1;
                    if (poll_d == PollMax) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        quot_d  = 32'd0;
                    end else begin
                        state_d = StRdRdy;
                        cs_d    = 1'b1;
                        rd_d    = 1'b1;
                        addr_d  = AddrReady;
                    end
                end
            end
            StRdRes: begin
                state_d = StSmpRes;
            end
            StSmpRes: begin
                state_d = StFin;
                quot_d  = bus_rdata;
                err_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            divisor_q <= 32'd0;
            poll_q    <= '0;
            settle_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            quot_q    <= 32'd0;
            cs_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 3'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            poll_q    <= poll_d;
            settle_q  <= settle_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            quot_q    <= quot_d;
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign quotient  = quot_q;
    assign cs        = cs_q;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign addr      = addr_q;
    assign bus_wdata = wdata_q;

endmodule
